// File: rtl/sar_adc_seq_pkg.sv
// Shared types and constants for the 12-bit SAR ADC sequencer.
package sar_adc_seq_pkg;

    localparam int SAR_NBITS   = 12;
    localparam int SYNC_STAGES = 2;
    localparam int CNT_W       = 8;
    localparam int IDX_W       = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SAMP,
        S_REL,
        S_BIT,
        S_LSB,
        S_CAP
    } state_t;

    // One-hot trial pulse for bit index idx (1..SAR_NBITS-1); zero otherwise.
    function automatic logic [SAR_NBITS-1:1] pulse_decode(input logic [IDX_W-1:0] idx);
        logic [SAR_NBITS-1:1] p;
        p = '0;
        for (int k = 1; k < SAR_NBITS; k++) begin
            if (idx == IDX_W'(k)) p[k] = 1'b1;
        end
        return p;
    endfunction

endpackage

// File: rtl/sar_comp_sync.sv
// Multi-flop synchronizer bringing the asynchronous comparator output into the clock domain.
module sar_comp_sync
    import sar_adc_seq_pkg::*;
(
    input  logic clk,
    input  logic rstn,
    input  logic comp,
    output logic comp_sync
);

    logic [SYNC_STAGES-1:0] sync_q;

    // Free-running shift chain; cleared by the synchronous reset.
    always_ff @(posedge clk) begin
        if (!rstn) sync_q <= '0;
        else       sync_q <= {sync_q[SYNC_STAGES-2:0], comp};
    end

    assign comp_sync = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/sar_adc_seq_ctrl_12bit.sv
// Sequencer for the 12-bit SAR logic: sample, release WP reset, eleven bit-trial
// pulses, local LSB decision via synchronized COMP, and valid/ready result hand-off.
module sar_adc_seq_ctrl_12bit
    import sar_adc_seq_pkg::*;
#(
    parameter int SAMPLE_CYCLES = 4,
    parameter int PULSE_W       = 1,
    parameter int SETTLE        = 2
) (
    input  logic                  CLK,
    input  logic                  RSTN,
    input  logic                  START,
    output logic                  BUSY,
    output logic                  SAMPLE,
    output logic                  WP_RSTN,
    output logic [SAR_NBITS-1:1]  PULSE,
    input  logic                  COMP,
    input  logic [SAR_NBITS-1:0]  WP,
    input  logic                  SAR_REG0,
    output logic [SAR_NBITS-1:0]  DOUT,
    output logic                  DOUT_REG0,
    output logic                  DOUT_VALID,
    input  logic                  DOUT_READY,
    output logic                  OVERRUN
);

    // Last value of the phase counter in each timed state.
    localparam logic [CNT_W-1:0] SAMP_LAST   = CNT_W'(SAMPLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0] BIT_LAST    = CNT_W'(PULSE_W + SETTLE - 1);
    localparam logic [CNT_W-1:0] LSB_LAST    = CNT_W'(SYNC_STAGES - 1);
    localparam logic [CNT_W-1:0] PULSE_END   = CNT_W'(PULSE_W);
    localparam logic [IDX_W-1:0] MSB_IDX     = IDX_W'(SAR_NBITS - 1);

    state_t               state, state_n;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic [IDX_W-1:0]     bit_idx, bit_n;
    logic                 comp_sync;
    logic                 busy_n, sample_n, wp_rstn_n, load;
    logic [SAR_NBITS-1:1] pulse_n;

    // WP[0] is the LSB trial bit; its decision comes from comp_sync instead.
    logic unused_wp0;
    assign unused_wp0 = WP[0];

    sar_comp_sync u_comp_sync (
        .clk       (CLK),
        .rstn      (RSTN),
        .comp      (COMP),
        .comp_sync (comp_sync)
    );

    // State, phase counter and bit index registers.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_n;
        end
    end

    // Next-state sequencing plus next values of every registered output.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        bit_n   = bit_idx;
        case (state)
            S_IDLE: if (START) begin
                state_n = S_SAMP;
                cnt_n   = '0;
            end
            S_SAMP: if (cnt == SAMP_LAST) begin
                state_n = S_REL;
                cnt_n   = '0;
            end else cnt_n = cnt + CNT_W'(1);
            S_REL: if (cnt == SETTLE_LAST) begin
                state_n = S_BIT;
                cnt_n   = '0;
                bit_n   = MSB_IDX;
            end else cnt_n = cnt + CNT_W'(1);
            // Each trial: PULSE_W high cycles followed by SETTLE low cycles.
            S_BIT: if (cnt == BIT_LAST) begin
                cnt_n = '0;
                if (bit_idx == IDX_W'(1)) state_n = S_LSB;
                else                      bit_n   = bit_idx - IDX_W'(1);
            end else cnt_n = cnt + CNT_W'(1);
            // Give the synchronizer time to carry the WP[0]-trial decision.
            S_LSB: if (cnt == LSB_LAST) begin
                state_n = S_CAP;
                cnt_n   = '0;
            end else cnt_n = cnt + CNT_W'(1);
            S_CAP:   state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase

        busy_n    = (state_n == S_SAMP) || (state_n == S_REL) ||
                    (state_n == S_BIT)  || (state_n == S_LSB);
        sample_n  = (state_n == S_SAMP);
        wp_rstn_n = (state_n == S_REL) || (state_n == S_BIT) || (state_n == S_LSB);
        pulse_n   = (state_n == S_BIT && cnt_n < PULSE_END) ? pulse_decode(bit_n) : '0;
        load      = (state_n == S_CAP);
    end

    // Output registers and result handshake; new result overwrites any held word.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            BUSY       <= 1'b0;
            SAMPLE     <= 1'b0;
            WP_RSTN    <= 1'b0;
            PULSE      <= '0;
            DOUT       <= '0;
            DOUT_REG0  <= 1'b0;
            DOUT_VALID <= 1'b0;
            OVERRUN    <= 1'b0;
        end else begin
            BUSY    <= busy_n;
            SAMPLE  <= sample_n;
            WP_RSTN <= wp_rstn_n;
            PULSE   <= pulse_n;
            OVERRUN <= 1'b0;
            if (load) begin
                DOUT       <= {WP[SAR_NBITS-1:1], comp_sync};
                DOUT_REG0  <= SAR_REG0;
                DOUT_VALID <= 1'b1;
                OVERRUN    <= DOUT_VALID && !DOUT_READY;
            end else if (DOUT_VALID && DOUT_READY) begin
                DOUT_VALID <= 1'b0;
            end
        end
    end

endmodule

// File: doc/sar_adc_seq_ctrl_12bit.md
# sar_adc_seq_ctrl_12bit

Synchronous sequencer for the 12-bit single-input SAR ADC logic (the other end of the `PULSE`/`WP_RSTN` interface). It runs sampling, then releases the `WP` register reset, then issues the eleven one-hot bit-trial pulses `PULSE[11]`…`PULSE[1]`. It resolves the final LSB decision by sampling `COMP` itself, and hands the 12-bit code to the digital back-end over a valid/ready handshake. It sits between the acquisition controller (`START`) and the per-channel SAR logic macro.

## Interface
Parameters:
- `SAMPLE_CYCLES`, default 4: cycles `SAMPLE` is high; `WP_RSTN` is held low during sampling. Legal range 1..255.
- `PULSE_W`, default 1: high time of each `PULSE[k]`, in cycles. Legal range 1..15.
- `SETTLE`, default 2: low cycles after each pulse (and after `WP_RSTN` release) for DAC and comparator settling. Legal range 1..15.

Ports:
- `CLK` input 1: single clock, rising edge.
- `RSTN` input 1: reset, synchronous and active-low.
- `START` input 1: conversion request, sampled only in IDLE.
- `BUSY` output 1: high from the cycle after START acceptance until DOUT capture.
- `SAMPLE` output 1: sampling switch enable.
- `WP_RSTN` output 1: reset to the SAR logic. Low means `WP[10:0]`=0 and `WP[11]`=1 (MSB trial).
- `PULSE` output [11:1]: bit-trial pulses, at most one bit high at any time.
- `COMP` input 1: comparator output, asynchronous to `CLK`.
- `WP` input [12]: trial/decision register from the SAR logic.
- `SAR_REG0` input 1: diagnostic decision captured by the SAR logic on `PULSE[1]`.
- `DOUT` output [12]: conversion result.
- `DOUT_REG0` output 1: `SAR_REG0` captured alongside `DOUT`.
- `DOUT_VALID` output 1: result valid.
- `DOUT_READY` input 1: consumer accepts the result.
- `OVERRUN` output 1: one-cycle pulse when an unaccepted result is overwritten.

## Operation
- States: IDLE → SAMP → REL → BIT → LSB → CAP → IDLE.
- IDLE:
  - `WP_RSTN`=0, `PULSE`=0, `SAMPLE`=0.
  - `START`=1 → SAMP.
- SAMP: `SAMPLE`=1, `WP_RSTN`=0 for `SAMPLE_CYCLES` cycles → REL.
- REL: `WP_RSTN`=1, `SAMPLE`=0, wait `SETTLE` cycles → BIT with bit index k=11.
- BIT:
  - `PULSE[k]`=1 for `PULSE_W` cycles, then 0 for `SETTLE` cycles.
  - Decrement k. After k=1 → LSB.
- LSB:
  - `COMP` passes through a 2-flop synchronizer running continuously.
  - Wait 2 cycles for `comp_sync` to reflect the WP[0]-trial decision → CAP.
- CAP:
  - `DOUT`={`WP[11:1]`, `comp_sync`}, `DOUT_REG0`=`SAR_REG0`, `DOUT_VALID`=1, `BUSY`=0 → IDLE.
  - `WP_RSTN` returns low.
- Handshake:
  - `DOUT_VALID` stays high until sampled with `DOUT_READY`=1; it clears the next cycle.
  - `DOUT` is stable while VALID is high.
- Overwrite: CAP while VALID=1 and READY=0 → new data loaded, VALID stays 1, `OVERRUN`=1 for one cycle. If READY=1 in the same cycle, the old word is consumed and no `OVERRUN` is raised.
- `START` is ignored in every state except IDLE; no queuing.
- `RSTN`=0, at any state including mid-pulse: next edge → IDLE with all outputs at reset values, and any in-flight conversion is discarded.

## Timing
- All outputs registered; no combinational path from input to output.
- Reset values: `BUSY`=0, `SAMPLE`=0, `WP_RSTN`=0, `PULSE`=0, `DOUT`=0, `DOUT_REG0`=0, `DOUT_VALID`=0, `OVERRUN`=0.
- START accepted at edge 0. Then:
  - `BUSY`, `SAMPLE` high from cycle 1.
  - `WP_RSTN` high from cycle 1+`SAMPLE_CYCLES`.
- First `PULSE[11]` cycle: 1+`SAMPLE_CYCLES`+`SETTLE`.
- `DOUT_VALID` rises L cycles after acceptance, where L = 1+`SAMPLE_CYCLES`+`SETTLE`+11·(`PULSE_W`+`SETTLE`)+2. Defaults give L = 42.
- Minimum START-to-START spacing: L+1 cycles.
- `PULSE` bits never overlap, and no pulse is asserted while `WP_RSTN`=0.

## Structure
- Package `sar_adc_seq_pkg`:
  - state enum;
  - `SAR_NBITS`=12;
  - `SYNC_STAGES`=2;
  - counter widths (8-bit phase counter, 4-bit bit index).
- Sub-module `sar_comp_sync`: 2-flop synchronizer for `COMP`, reset to 0.
- Top module: FSM, phase counter, bit index, one-hot `PULSE` decode (registered), output/handshake register.

## Test plan
- Defaults, `COMP` modeled from analog input 0x5A3 with a behavioral SAR logic → `DOUT`=0x5A3 with `DOUT_VALID` at cycle 42. Pulse order 11..1 is checked, each 1 cycle wide with 2 low cycles between.
- `COMP` stuck 1 → `DOUT`=0xFFF; `COMP` stuck 0 → `DOUT`=0x000. `PULSE` is checked one-hot or zero on every cycle.
- `DOUT_READY`=0 across two conversions → second CAP pulses `OVERRUN` once, `DOUT` holds the second code, and VALID stays 1. READY=1 for one cycle → VALID low the next cycle.
- `RSTN` low during the `PULSE[6]` high cycle → next cycle `PULSE`=0, `WP_RSTN`=0, `BUSY`=0, VALID=0. Then a new START yields a correct code with nominal latency.
- `START` held high continuously → back-to-back conversions spaced exactly L+1 cycles. A pulse on `START` while `BUSY` is ignored.
- `SAMPLE_CYCLES`=1, `PULSE_W`=3, `SETTLE`=1 → L = 1+1+1+44+2 = 49, and each pulse is 3 cycles wide.
